// File: rtl/gb_cpu_common_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gb_cpu_common_pkg : types and constants shared by the CPU control path   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package gb_cpu_common_pkg;

    localparam logic [2:0] C_MAX_M_CYCLE = 3'd5;

    typedef enum logic [3:0] {
        REG_B, REG_C, REG_D, REG_E, REG_H, REG_L, REG_A, REG_F,
        REG_W, REG_Z, REG_SPH, REG_SPL, REG_PCH, REG_PCL, REG_IR, REG_NONE8
    } regfile_r8_t;

    typedef enum logic [7:0] {
        REG_BC, REG_DE, REG_HL, REG_AF, REG_SP, REG_PC, REG_WZ, REG_NONE16
    } regfile_r16_t;

    typedef enum logic [1:0] {
        ADDR_BUS_REG8, ADDR_BUS_REG16, ADDR_BUS_HIGH_PAGE, ADDR_BUS_NONE
    } addr_bus_source_t;

    typedef enum logic [1:0] {
        IDU_INC, IDU_DEC, IDU_PASS, IDU_NOP
    } idu_opcode_t;

    typedef enum logic [4:0] {
        ALU_NOP, ADD, ADC, SUB, SBC, AND, XOR, OR, CP, INC, DEC,
        RLCA, RRCA, RLA, RRA, RLC, RRC, RL, RR, SLA, SRA, SWAP, SRL,
        DAA, CPL, SCF, CCF, BIT, RES, SET
    } alu_opcode_t;

    typedef struct packed {
        addr_bus_source_t addr_bus_source;
        regfile_r8_t      addr_bus_source_r8;
        regfile_r16_t     addr_bus_source_r16;
        regfile_r8_t      data_bus_i_destination;
        regfile_r8_t      data_bus_o_source;
        logic             drive_data_bus;
        idu_opcode_t      idu_opcode;
        regfile_r16_t     idu_operand;
        regfile_r16_t     idu_destination;
        logic             idu_wren;
        alu_opcode_t      alu_opcode;
        regfile_r8_t      alu_operand_a_register;
        regfile_r8_t      alu_operand_b_register;
        logic             alu_inc_dec;
        regfile_r8_t      alu_destination;
        logic             alu_wren;
        logic             enable_interrupts;
        logic             disable_interrupts;
        logic             rst_cmd;
        logic             cc_check;
    } control_signals_t;

    typedef struct packed {
        logic [2:0]                  m_cycles;
        logic                        cb_prefix_next;
        control_signals_t [0:5]      instruction_controls;
    } schedule_t;

    // Indices above the last table slot yield an all-zero control word.
    function automatic control_signals_t control_at(schedule_t s, logic [2:0] idx);
        control_signals_t c;
        case (idx)
            3'd0:    c = s.instruction_controls[0];
            3'd1:    c = s.instruction_controls[1];
            3'd2:    c = s.instruction_controls[2];
            3'd3:    c = s.instruction_controls[3];
            3'd4:    c = s.instruction_controls[4];
            3'd5:    c = s.instruction_controls[5];
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gb_cpu_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gb_cpu_scheduler : M-cycle sequencer selecting the next control word     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module gb_cpu_scheduler
    import gb_cpu_common_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  schedule_t        schedule,
    input  logic [2:0]       curr_m_cycle,
    input  logic             cond_not_met,
    output control_signals_t control_next,
    output logic [2:0]       next_m_cycle,
    output logic             cb_prefix_o
);

    logic [7:0] w_cc_vec;
    logic       w_early_end;
    logic       w_last;
    logic [2:0] next_m_cycle_d;
    logic [2:0] next_m_cycle_q;
    logic       cb_prefix_d;
    logic       cb_prefix_q;

    always_comb begin
        w_cc_vec = 8'd0;
        for (int i = 0; i < 6; i++) begin
            w_cc_vec[i] = schedule.instruction_controls[i].cc_check;
        end

        w_early_end = cond_not_met & w_cc_vec[curr_m_cycle];
        w_last      = (curr_m_cycle >= schedule.m_cycles) | w_early_end;

        next_m_cycle_d = w_last ? 3'd0 : curr_m_cycle + 3'd1;
        if (next_m_cycle_d > C_MAX_M_CYCLE) begin
            next_m_cycle_d = 3'd0;
        end

        // An aborted conditional instruction never carries a CB prefix forward.
        cb_prefix_d = cb_prefix_q;
        if (w_early_end) begin
            cb_prefix_d = 1'b0;
        end else if (w_last) begin
            cb_prefix_d = schedule.cb_prefix_next;
        end

        control_next = control_at(schedule, next_m_cycle_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_m_cycle_q <= 3'd0;
            cb_prefix_q    <= 1'b0;
        end else begin
            next_m_cycle_q <= next_m_cycle_d;
            cb_prefix_q    <= cb_prefix_d;
        end
    end

    assign next_m_cycle = next_m_cycle_q;
    assign cb_prefix_o  = cb_prefix_q;

endmodule
`default_nettype wire

// File: tb/tb_gb_cpu_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gb_cpu_scheduler : scoreboard bench for gb_cpu_scheduler              |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_gb_cpu_scheduler;
    import gb_cpu_common_pkg::*;

    logic             clk;
    logic             reset;
    schedule_t        sched;
    logic [2:0]       curr_m_cycle;
    logic             cond_not_met;
    control_signals_t control_next;
    logic [2:0]       next_m_cycle;
    logic             cb_prefix_o;

    logic             fb_en;
    logic [2:0]       curr_drv;

    typedef struct packed {
        logic [2:0] nxt;
        logic       cb;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks;
    int   n_errors;

    assign curr_m_cycle = fb_en ? next_m_cycle : curr_drv;

    gb_cpu_scheduler u_dut (
        .clk          (clk),
        .reset        (reset),
        .schedule     (sched),
        .curr_m_cycle (curr_m_cycle),
        .cond_not_met (cond_not_met),
        .control_next (control_next),
        .next_m_cycle (next_m_cycle),
        .cb_prefix_o  (cb_prefix_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic schedule_t build_sched(input logic [2:0] mc, input logic cb);
        schedule_t s;
        s = '0;
        s.m_cycles       = mc;
        s.cb_prefix_next = cb;
        for (int k = 0; k < 6; k++) begin
            s.instruction_controls[k].alu_operand_a_register = regfile_r8_t'(4'(k));
            s.instruction_controls[k].alu_operand_b_register = regfile_r8_t'(4'(k + 8));
            s.instruction_controls[k].idu_destination        = regfile_r16_t'(8'(k));
            s.instruction_controls[k].idu_wren               = k[0];
            s.instruction_controls[k].alu_opcode             = alu_opcode_t'(5'(k + 1));
        end
        s.instruction_controls[0].addr_bus_source_r16 = REG_AF;
        s.instruction_controls[0].alu_opcode          = SBC;
        s.instruction_controls[1].addr_bus_source     = ADDR_BUS_REG8;
        s.instruction_controls[1].addr_bus_source_r8  = REG_E;
        s.instruction_controls[1].alu_opcode          = DAA;
        s.instruction_controls[1].idu_operand         = REG_BC;
        s.instruction_controls[2].addr_bus_source     = ADDR_BUS_REG16;
        return s;
    endfunction

    // Inputs are already applied; check the combinational word, queue the registered result.
    task automatic step(input string tag, input int exp_idx, input logic [2:0] exp_next, input logic exp_cb);
        @(negedge clk);
        check_val({tag, "/ctrl"}, 128'(control_next), 128'(sched.instruction_controls[exp_idx]));
        sb_q.push_back('{nxt: exp_next, cb: exp_cb});
        @(posedge clk);
        #2;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check_val("sb/next_m_cycle", 128'(next_m_cycle), 128'(mon_e.nxt));
                check_val("sb/cb_prefix", 128'(cb_prefix_o), 128'(mon_e.cb));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        reset        = 1'b0;
        fb_en        = 1'b1;
        curr_drv     = 3'd0;
        cond_not_met = 1'b0;
        sched        = build_sched(3'd2, 1'b0);

        // Asynchronous reset, observed before the first clock edge
        #2 reset = 1'b1;
        #1;
        check_val("rst_async/next", 128'(next_m_cycle), 128'(3'd0));
        check_val("rst_async/cb", 128'(cb_prefix_o), 128'(1'b0));
        check_val("rst/ctrl", 128'(control_next), 128'(sched.instruction_controls[1]));
        @(posedge clk);
        #2 reset = 1'b0;

        // Three-cycle instruction looping
        for (int i = 0; i < 9; i++) begin
            if (i % 3 == 0) begin
                check_val("seq/abs", 128'(control_next.addr_bus_source), 128'(ADDR_BUS_REG8));
                check_val("seq/r8", 128'(control_next.addr_bus_source_r8), 128'(REG_E));
                check_val("seq/alu", 128'(control_next.alu_opcode), 128'(DAA));
                check_val("seq/idu_op", 128'(control_next.idu_operand), 128'(REG_BC));
            end
            if (i % 3 == 2) begin
                check_val("seq/r16", 128'(control_next.addr_bus_source_r16), 128'(REG_AF));
                check_val("seq/alu0", 128'(control_next.alu_opcode), 128'(SBC));
            end
            step("seq", (i % 3 + 1) % 3, 3'((i % 3 + 1) % 3), 1'b0);
        end

        // CB prefix set on the final cycle, cleared on the next wrap
        sched.cb_prefix_next = 1'b1;
        step("cb_a", 1, 3'd1, 1'b0);
        step("cb_b", 2, 3'd2, 1'b0);
        step("cb_c", 0, 3'd0, 1'b1);
        sched.cb_prefix_next = 1'b0;
        step("cb_d", 1, 3'd1, 1'b1);
        step("cb_e", 2, 3'd2, 1'b1);
        step("cb_f", 0, 3'd0, 1'b0);
        sched.cb_prefix_next = 1'b1;
        step("cb_g", 1, 3'd1, 1'b0);
        step("cb_h", 2, 3'd2, 1'b0);
        step("cb_i", 0, 3'd0, 1'b1);

        // Early termination on entry 1; entry 0 ignores the condition
        sched.instruction_controls[1].cc_check = 1'b1;
        cond_not_met = 1'b1;
        step("ign_c0", 1, 3'd1, 1'b1);
        step("early", 0, 3'd0, 1'b0);
        cond_not_met = 1'b0;

        // Condition ignored when cc_check is clear
        sched.instruction_controls[1].cc_check = 1'b0;
        step("ign_a", 1, 3'd1, 1'b0);
        cond_not_met = 1'b1;
        step("ign_b", 2, 3'd2, 1'b0);
        cond_not_met = 1'b0;
        step("ign_c", 0, 3'd0, 1'b1);

        // Single-cycle instruction
        sched.m_cycles = 3'd0;
        for (int i = 0; i < 4; i++) begin
            sched.cb_prefix_next = i[0];
            step("single", 0, 3'd0, i[0]);
        end

        // Index boundary with an oversized m_cycles, open loop
        fb_en          = 1'b0;
        sched.m_cycles = 3'd7;
        curr_drv       = 3'd4;
        step("bnd4", 5, 3'd5, 1'b1);
        curr_drv = 3'd5;
        step("bnd5", 0, 3'd0, 1'b1);
        curr_drv             = 3'd7;
        sched.cb_prefix_next = 1'b0;
        step("bnd7", 0, 3'd0, 1'b0);

        // Reset mid-instruction abandons the schedule
        fb_en                = 1'b1;
        sched.m_cycles       = 3'd2;
        sched.cb_prefix_next = 1'b1;
        step("pre_a", 1, 3'd1, 1'b0);
        step("pre_b", 2, 3'd2, 1'b0);
        step("pre_c", 0, 3'd0, 1'b1);
        step("pre_d", 1, 3'd1, 1'b1);
        #1 reset = 1'b1;
        #1;
        check_val("rst_mid/next", 128'(next_m_cycle), 128'(3'd0));
        check_val("rst_mid/cb", 128'(cb_prefix_o), 128'(1'b0));
        @(posedge clk);
        #1;
        check_val("rst_hold/next", 128'(next_m_cycle), 128'(3'd0));
        #1 reset = 1'b0;
        step("post_rst", 1, 3'd1, 1'b0);

        check_val("sb/drain", 128'(sb_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
